// File: rtl/addsub_acc_seq_if.sv
// addsub_acc_seq_if
//   Bundles the command handshake, the snapshot handshake and the link to the
//   external 36-bit add/subtract datapath for addsub_acc_seq.
//   Ports:
//     in_valid/in_ready/in_op/in_data     command channel (op 00 LOAD, 01 ADD,
//                                         10 SUB, 11 READ)
//     dp_a/dp_b/dp_add/dp_sum             datapath drive and same-cycle result
//     out_valid/out_ready/out_data/out_ovf snapshot channel
//   Modports: slave = the sequencer, master = its environment.
interface addsub_acc_seq_if #(
  parameter int W = 36
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_data;
  logic [W-1:0] dp_a;
  logic [W-1:0] dp_b;
  logic         dp_add;
  logic [W-1:0] dp_sum;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  modport slave (
    input  in_valid, in_op, in_data, dp_sum, out_ready,
    output in_ready, dp_a, dp_b, dp_add, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_op, in_data, dp_sum, out_ready,
    input  in_ready, dp_a, dp_b, dp_add, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/addsub_acc_seq.sv
// addsub_acc_seq
//   Sequencing stage for a combinational add/subtract datapath. Accepts
//   accumulator commands, drives the datapath with acc and in_data, registers
//   the returned sum, tracks a sticky signed-overflow flag and queues READ
//   snapshots {ovf, acc} in a 2-entry output buffer.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    addsub_acc_seq_if.slave (command, datapath and snapshot signals)
//   Build option:
//     ADDSUB_ACC_SAT_EN  when defined, an overflowing ADD/SUB saturates the
//                        accumulator to the most positive/negative value
//                        instead of wrapping.
module addsub_acc_seq #(
  parameter int W = 36
) (
  input  logic              clk,
  input  logic              reset,
  addsub_acc_seq_if.slave   bus
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] acc_reg, acc_next;
  logic         ovf_reg, ovf_next;

  // Snapshot buffer: entry = {ovf, acc}
  logic [W:0]   fifo_mem [2];
  logic         rd_ptr_reg, rd_ptr_next;
  logic         wr_ptr_reg, wr_ptr_next;
  logic [1:0]   count_reg, count_next;

  logic         accept;
  logic         push;
  logic         pop;
  logic         is_arith;
  logic         sign_a, sign_b, sign_s;
  logic         arith_ovf;

  // Handshake outputs depend only on registered occupancy, never on in_valid.
  assign bus.in_ready  = (count_reg != 2'd2);
  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_data  = fifo_mem[rd_ptr_reg][W-1:0];
  assign bus.out_ovf   = fifo_mem[rd_ptr_reg][W];

  assign bus.dp_a   = acc_reg;
  assign bus.dp_b   = bus.in_data;
  assign bus.dp_add = (bus.in_op != OP_SUB);

  assign accept   = bus.in_valid && bus.in_ready;
  assign push     = accept && (bus.in_op == OP_READ);
  assign pop      = bus.out_valid && bus.out_ready;
  assign is_arith = (bus.in_op == OP_ADD) || (bus.in_op == OP_SUB);

  // Signed overflow from operand and result signs. Subtraction can only
  // overflow when the operands differ in sign, addition when they match.
  assign sign_a    = acc_reg[W-1];
  assign sign_b    = bus.in_data[W-1];
  assign sign_s    = bus.dp_sum[W-1];
  assign arith_ovf = (sign_s != sign_a) &&
                     ((bus.in_op == OP_SUB) ? (sign_a != sign_b) : (sign_a == sign_b));

  always_comb begin
    acc_next = acc_reg;
    ovf_next = ovf_reg;
    if (accept) begin
      if (bus.in_op == OP_LOAD) begin
        acc_next = bus.in_data;
        ovf_next = 1'b0;
      end else if (is_arith) begin
        acc_next = bus.dp_sum;
        if (arith_ovf) begin
          ovf_next = 1'b1;
`ifdef ADDSUB_ACC_SAT_EN
          // Overflow direction follows the sign of the accumulator operand.
          acc_next = sign_a ? ACC_MIN : ACC_MAX;
`endif
        end
      end
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = ~wr_ptr_reg;
    end
    if (pop) begin
      rd_ptr_next = ~rd_ptr_reg;
    end
    // in_ready already blocks a push into a full buffer, and pop needs data,
    // so the count cannot leave 0..2.
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      ovf_reg    <= 1'b0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      acc_reg    <= acc_next;
      ovf_reg    <= ovf_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entries are reset so out_data/out_ovf read 0 straight out of reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_mem[gi] <= {ovf_reg, acc_reg};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_addsub_acc_seq.sv
module tb_addsub_acc_seq;

  localparam int W = 36;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;
  localparam longint S_MAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint S_MIN = -(longint'(1) <<< (W - 1));

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  addsub_acc_seq_if #(.W(W)) bus ();

  addsub_acc_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External combinational datapath
  assign bus.dp_sum = bus.dp_add ? (bus.dp_a + bus.dp_b) : (bus.dp_a - bus.dp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accumulator as a signed integer, snapshot queue
  logic [W-1:0] m_acc;
  logic         m_ovf;
  logic [W:0]   m_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [W-1:0] d);
    longint a, b, r;
    logic [63:0] r_bits;
    case (op)
      OP_LOAD: begin
        m_acc = d;
        m_ovf = 1'b0;
      end
      OP_READ: m_q.push_back({m_ovf, m_acc});
      default: begin
        a = longint'($signed(m_acc));
        b = longint'($signed(d));
        r = (op == OP_ADD) ? a + b : a - b;
        r_bits = r;
        if (r > S_MAX || r < S_MIN) begin
          m_ovf = 1'b1;
`ifdef ADDSUB_ACC_SAT_EN
          r_bits = (r > S_MAX) ? S_MAX : S_MIN;
`endif
        end
        m_acc = r_bits[W-1:0];
      end
    endcase
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  // One clock cycle: drive inputs, check every output against the model at
  // the falling edge, then advance the model across the rising edge.
  task automatic cycle(input bit v, input logic [1:0] op, input logic [W-1:0] d,
                       input bit ordy, output bit accepted);
    bit popped;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    check("in_ready", 64'(bus.in_ready), 64'(m_q.size() < 2));
    check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_data", 64'(bus.out_data), 64'(m_q[0][W-1:0]));
      check("out_ovf", 64'(bus.out_ovf), 64'(m_q[0][W]));
    end
    check("dp_a", 64'(bus.dp_a), 64'(m_acc));
    check("dp_b", 64'(bus.dp_b), 64'(d));
    check("dp_add", 64'(bus.dp_add), 64'(op != OP_SUB));
    popped   = (m_q.size() != 0) && ordy;
    accepted = v && (m_q.size() < 2);
    if (popped) begin
      $display("t=%0t pop  data=%h ovf=%0d", $time, m_q[0][W-1:0], m_q[0][W]);
      void'(m_q.pop_front());
    end
    if (accepted) begin
      model_apply(op, d);
      $display("t=%0t cmd  op=%0d data=%h -> acc=%h ovf=%0d", $time, op, d, m_acc, m_ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    bit a;
    cycle(1'b0, OP_LOAD, '0, ordy, a);
  endtask

  initial begin
    bit a;
    logic [63:0] r64;
    logic [W-1:0] d;
    logic [1:0] op;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_LOAD;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #3;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    check("rst_acc", 64'(bus.dp_a), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // LOAD 5, ADD 3, SUB 10, READ -> -2
    cycle(1'b1, OP_LOAD, 36'd5, 1'b1, a);
    cycle(1'b1, OP_ADD, 36'd3, 1'b1, a);
    check("seq_add_acc", 64'(bus.dp_a), 64'd8);
    cycle(1'b1, OP_SUB, 36'd10, 1'b1, a);
    cycle(1'b1, OP_READ, '0, 1'b1, a);
    check("seq_out_valid", 64'(bus.out_valid), 64'd1);
    check("seq_out_data", 64'(bus.out_data), 64'h0_000F_FFFF_FFFE);
    check("seq_out_ovf", 64'(bus.out_ovf), 64'd0);
    idle(1'b1);

    // Positive overflow then LOAD clears ovf
    cycle(1'b1, OP_LOAD, 36'h7_FFFF_FFFF, 1'b1, a);
    cycle(1'b1, OP_ADD, 36'd1, 1'b1, a);
    cycle(1'b1, OP_READ, '0, 1'b1, a);
`ifdef ADDSUB_ACC_SAT_EN
    check("povf_data", 64'(bus.out_data), 64'h7_FFFF_FFFF);
`else
    check("povf_data", 64'(bus.out_data), 64'h8_0000_0000);
`endif
    check("povf_ovf", 64'(bus.out_ovf), 64'd1);
    cycle(1'b1, OP_LOAD, 36'd0, 1'b1, a);
    cycle(1'b1, OP_READ, '0, 1'b1, a);
    check("load_clr_ovf", 64'(bus.out_ovf), 64'd0);
    idle(1'b1);

    // Negative overflow on SUB
    cycle(1'b1, OP_LOAD, 36'h8_0000_0000, 1'b1, a);
    cycle(1'b1, OP_SUB, 36'd1, 1'b1, a);
    cycle(1'b1, OP_READ, '0, 1'b1, a);
`ifdef ADDSUB_ACC_SAT_EN
    check("novf_data", 64'(bus.out_data), 64'h8_0000_0000);
`else
    check("novf_data", 64'(bus.out_data), 64'h7_FFFF_FFFF);
`endif
    check("novf_ovf", 64'(bus.out_ovf), 64'd1);
    idle(1'b1);

    // Backpressure: buffer fills, a pending ADD must hold
    cycle(1'b1, OP_LOAD, 36'd1, 1'b0, a);
    cycle(1'b1, OP_READ, '0, 1'b0, a);
    cycle(1'b1, OP_ADD, 36'd1, 1'b0, a);
    cycle(1'b1, OP_READ, '0, 1'b0, a);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, OP_ADD, 36'd1, 1'b0, a);
    check("full_hold", 64'(a), 64'd0);
    cycle(1'b1, OP_ADD, 36'd1, 1'b0, a);
    check("full_hold_acc", 64'(bus.dp_a), 64'd2);
    check("full_hold_data", 64'(bus.out_data), 64'd1);
    cycle(1'b1, OP_ADD, 36'd1, 1'b1, a);
    check("pop_cycle_no_accept", 64'(a), 64'd0);
    check("pop_next_data", 64'(bus.out_data), 64'd2);
    check("pop_in_ready", 64'(bus.in_ready), 64'd1);
    cycle(1'b1, OP_ADD, 36'd1, 1'b1, a);
    check("add_after_pop", 64'(a), 64'd1);
    check("add_after_pop_acc", 64'(bus.dp_a), 64'd3);
    check("drained", 64'(bus.out_valid), 64'd0);

    // Simultaneous push and pop at count 1
    cycle(1'b1, OP_READ, '0, 1'b0, a);
    cycle(1'b1, OP_LOAD, 36'd7, 1'b0, a);
    cycle(1'b1, OP_READ, '0, 1'b1, a);
    check("pp_out_valid", 64'(bus.out_valid), 64'd1);
    check("pp_out_data", 64'(bus.out_data), 64'd7);
    check("pp_in_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r64 = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: d = 36'h7_FFFF_FFFF;
        1: d = 36'h8_0000_0000;
        2: d = 36'(r64[7:0]);
        default: d = r64[W-1:0];
      endcase
      op = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, op, d, $urandom_range(0, 2) != 0, a);
    end

    // Asynchronous reset with two snapshots buffered
    cycle(1'b1, OP_LOAD, 36'h1234, 1'b0, a);
    cycle(1'b1, OP_READ, '0, 1'b0, a);
    cycle(1'b1, OP_READ, '0, 1'b0, a);
    check("pre_rst_full", 64'(bus.in_ready), 64'(m_q.size() < 2));
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_acc", 64'(bus.dp_a), 64'd0);
    check("arst_out_ovf", 64'(bus.out_ovf), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1'b1, OP_ADD, 36'd9, 1'b1, a);
    cycle(1'b1, OP_READ, '0, 1'b1, a);
    check("post_rst_data", 64'(bus.out_data), 64'd9);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
